// File: rtl/div_unit_control_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_control_if
// Description : Request, divider and writeback signals of div_unit_control.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_control_if;
  logic        req;
  logic        is_8_bit;
  logic        is_signed;
  logic [15:0] ax_in;
  logic [15:0] dx_in;
  logic [15:0] src_in;
  logic        ready;
  logic        div_start;
  logic        div_is_8_bit;
  logic        div_is_signed;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_complete;
  logic        div_error;
  logic [15:0] div_quotient;
  logic [15:0] div_remainder;
  logic        wr_en;
  logic        wr_dx_en;
  logic [15:0] wr_ax;
  logic [15:0] wr_dx;
  logic        done;
  logic        fault;
  logic        timeout;

  // Environment side: execute stage plus the divider datapath.
  modport master (
    output req, is_8_bit, is_signed, ax_in, dx_in, src_in,
    output div_complete, div_error, div_quotient, div_remainder,
    input  ready, div_start, div_is_8_bit, div_is_signed, div_dividend, div_divisor,
    input  wr_en, wr_dx_en, wr_ax, wr_dx, done, fault, timeout
  );

  modport slave (
    input  req, is_8_bit, is_signed, ax_in, dx_in, src_in,
    input  div_complete, div_error, div_quotient, div_remainder,
    output ready, div_start, div_is_8_bit, div_is_signed, div_dividend, div_divisor,
    output wr_en, wr_dx_en, wr_ax, wr_dx, done, fault, timeout
  );
endinterface
`default_nettype wire

// File: rtl/div_unit_control.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_control
// Description : Sequences DIV/IDIV: operand formatting, divider handshake,
//               AX/DX writeback, and divide-error / timeout fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_control #(
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic              clk,
  input  logic              reset,
  div_unit_control_if.slave bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LAUNCH = 3'd1;
  localparam logic [2:0] c_WAIT   = 3'd2;
  localparam logic [2:0] c_WB     = 3'd3;
  localparam logic [2:0] c_FAULT  = 3'd4;

  localparam logic [5:0] c_TIMEOUT = TIMEOUT_CYCLES[5:0];

  logic [2:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is8_q, is8_d;
  logic        sgn_q, sgn_d;
  logic [31:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic        to_q, to_d;

  logic [5:0]  w_cnt_inc;
  logic [31:0] w_dvd_fmt;
  logic [15:0] w_dvs_fmt;
  logic        w_wb;

  assign w_cnt_inc = cnt_q + 6'd1;

  // Byte divides widen AX and the low divisor byte by sign or zero.
  always_comb begin
    if (!bus.is_8_bit) begin
      w_dvd_fmt = {bus.dx_in, bus.ax_in};
      w_dvs_fmt = bus.src_in;
    end else if (bus.is_signed) begin
      w_dvd_fmt = {{16{bus.ax_in[15]}}, bus.ax_in};
      w_dvs_fmt = {{8{bus.src_in[7]}}, bus.src_in[7:0]};
    end else begin
      w_dvd_fmt = {16'h0000, bus.ax_in};
      w_dvs_fmt = {8'h00, bus.src_in[7:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is8_d   = is8_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    to_d    = to_q;
    case (state_q)
      c_IDLE: begin
        if (bus.req) begin
          state_d = c_LAUNCH;
          is8_d   = bus.is_8_bit;
          sgn_d   = bus.is_signed;
          dvd_d   = w_dvd_fmt;
          dvs_d   = w_dvs_fmt;
          to_d    = 1'b0;
        end
      end
      c_LAUNCH: begin
        cnt_d   = 6'd0;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        // A completion in the final allowed cycle wins over the timeout.
        if (bus.div_complete) begin
          state_d = bus.div_error ? c_FAULT : c_WB;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == c_TIMEOUT) begin
            state_d = c_FAULT;
            to_d    = 1'b1;
          end
        end
      end
      c_WB:    state_d = c_IDLE;
      c_FAULT: state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= 6'd0;
      is8_q   <= 1'b0;
      sgn_q   <= 1'b0;
      dvd_q   <= 32'h0;
      dvs_q   <= 16'h0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is8_q   <= is8_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      to_q    <= to_d;
    end
  end

  assign w_wb = (state_q == c_WB);

  assign bus.ready         = (state_q == c_IDLE);
  assign bus.div_start     = (state_q == c_LAUNCH);
  assign bus.div_is_8_bit  = is8_q;
  assign bus.div_is_signed = sgn_q;
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;

  // Byte results pack remainder into AH and quotient into AL.
  assign bus.wr_en    = w_wb;
  assign bus.wr_dx_en = w_wb & ~is8_q;
  assign bus.wr_ax    = !w_wb ? 16'h0000 :
                        is8_q ? {bus.div_remainder[7:0], bus.div_quotient[7:0]} :
                                bus.div_quotient;
  assign bus.wr_dx    = (w_wb && !is8_q) ? bus.div_remainder : 16'h0000;
  assign bus.done     = w_wb | (state_q == c_FAULT);
  assign bus.fault    = (state_q == c_FAULT);
  assign bus.timeout  = (state_q == c_FAULT) & to_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit_control
// Description : Directed scoreboard bench for div_unit_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit_control;

  typedef struct {
    logic        wr_en;
    logic        wr_dx_en;
    logic [15:0] wr_ax;
    logic [15:0] wr_dx;
    logic        fault;
    logic        timeout;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fails;
  int   n_starts;
  int   exp_starts;
  exp_t sb[$];

  div_unit_control_if bus ();

  div_unit_control #(.TIMEOUT_CYCLES(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.div_start) n_starts <= n_starts + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"},     bus.done,     1'b1);
    chk({tag, "_wr_en"},    bus.wr_en,    e.wr_en);
    chk({tag, "_wr_dx_en"}, bus.wr_dx_en, e.wr_dx_en);
    chk({tag, "_wr_ax"},    bus.wr_ax,    e.wr_ax);
    chk({tag, "_wr_dx"},    bus.wr_dx,    e.wr_dx);
    chk({tag, "_fault"},    bus.fault,    e.fault);
    chk({tag, "_timeout"},  bus.timeout,  e.timeout);
  endtask

  task automatic launch(input logic is8, input logic sgn, input logic [15:0] ax,
                        input logic [15:0] dx, input logic [15:0] src, input exp_t e);
    chk("ready_before_req", bus.ready, 1'b1);
    bus.req = 1'b1; bus.is_8_bit = is8; bus.is_signed = sgn;
    bus.ax_in = ax; bus.dx_in = dx; bus.src_in = src;
    sb.push_back(e);
    exp_starts++;
    step();
  endtask

  task automatic do_op(input string tag, input logic is8, input logic sgn,
                       input logic [15:0] ax, input logic [15:0] dx, input logic [15:0] src,
                       input logic [31:0] e_dvd, input logic [15:0] e_dvs, input bit hold,
                       input int n_idle, input logic err, input logic [15:0] q,
                       input logic [15:0] r, input exp_t e);
    launch(is8, sgn, ax, dx, src, e);
    chk({tag, "_start"},    bus.div_start,     1'b1);
    chk({tag, "_ready_lo"}, bus.ready,         1'b0);
    chk({tag, "_dividend"}, bus.div_dividend,  e_dvd);
    chk({tag, "_divisor"},  bus.div_divisor,   e_dvs);
    chk({tag, "_is8"},      bus.div_is_8_bit,  is8);
    chk({tag, "_signed"},   bus.div_is_signed, sgn);
    if (!hold) bus.req = 1'b0;
    bus.ax_in = ~ax; bus.dx_in = ~dx; bus.src_in = ~src; bus.is_8_bit = ~is8;
    step();
    chk({tag, "_start_once"}, bus.div_start, 1'b0);
    for (int i = 0; i < n_idle; i++) begin
      chk({tag, "_wait_nodone"}, bus.done, 1'b0);
      step();
    end
    chk({tag, "_dividend_hold"}, bus.div_dividend, e_dvd);
    chk({tag, "_divisor_hold"},  bus.div_divisor,  e_dvs);
    bus.div_complete = 1'b1; bus.div_error = err;
    bus.div_quotient = q; bus.div_remainder = r;
    step();
    bus.div_complete = 1'b0; bus.div_error = 1'b0;
    bus.req = 1'b0;
    chk_result(tag);
    step();
    chk({tag, "_ready_after"}, bus.ready, 1'b1);
    chk({tag, "_done_after"},  bus.done,  1'b0);
    chk({tag, "_wr_after"},    bus.wr_en, 1'b0);
    chk({tag, "_wr_ax_zero"},  bus.wr_ax, 16'h0000);
  endtask

  initial begin
    int n_wait;
    n_tests = 0; n_fails = 0; n_starts = 0; exp_starts = 0;
    reset = 1'b1;
    bus.req = 1'b1; bus.is_8_bit = 1'b0; bus.is_signed = 1'b0;
    bus.ax_in = 16'h1111; bus.dx_in = 16'h2222; bus.src_in = 16'h3333;
    bus.div_complete = 1'b0; bus.div_error = 1'b0;
    bus.div_quotient = 16'h0; bus.div_remainder = 16'h0;
    step(); step();
    chk("rst_ready",     bus.ready,        1'b1);
    chk("rst_start",     bus.div_start,    1'b0);
    chk("rst_dividend",  bus.div_dividend, 32'h0);
    chk("rst_divisor",   bus.div_divisor,  16'h0);
    chk("rst_is8",       bus.div_is_8_bit, 1'b0);
    chk("rst_done",      bus.done,         1'b0);
    chk("rst_fault",     bus.fault,        1'b0);
    chk("rst_timeout",   bus.timeout,      1'b0);
    chk("rst_wr_en",     bus.wr_en,        1'b0);
    chk("rst_wr_dx_en",  bus.wr_dx_en,     1'b0);
    chk("rst_wr_ax",     bus.wr_ax,        16'h0);
    chk("rst_wr_dx",     bus.wr_dx,        16'h0);
    bus.req = 1'b0;
    step();
    reset = 1'b0;
    step();

    do_op("uword", 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0010, 32'h0001_0000, 16'h0010,
          1'b0, 2, 1'b0, 16'h1000, 16'h0000,
          '{wr_en:1'b1, wr_dx_en:1'b1, wr_ax:16'h1000, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    do_op("sbyte", 1'b1, 1'b1, 16'hFFF9, 16'hABCD, 16'h0002, 32'hFFFF_FFF9, 16'h0002,
          1'b0, 1, 1'b0, 16'hFFFD, 16'hFFFF,
          '{wr_en:1'b1, wr_dx_en:1'b0, wr_ax:16'hFFFD, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    do_op("ubyte_hold", 1'b1, 1'b0, 16'h0085, 16'h1234, 16'hFF83, 32'h0000_0085, 16'h0083,
          1'b1, 3, 1'b0, 16'h0001, 16'h0002,
          '{wr_en:1'b1, wr_dx_en:1'b0, wr_ax:16'h0201, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    do_op("sword_last", 1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'hFFFE, 32'hFFFF_8000, 16'hFFFE,
          1'b0, 30, 1'b0, 16'h4000, 16'h0000,
          '{wr_en:1'b1, wr_dx_en:1'b1, wr_ax:16'h4000, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    do_op("sbyte_neg", 1'b1, 1'b1, 16'h0100, 16'h0000, 16'h1280, 32'h0000_0100, 16'hFF80,
          1'b0, 0, 1'b0, 16'hFFFE, 16'h0000,
          '{wr_en:1'b1, wr_dx_en:1'b0, wr_ax:16'h00FE, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    do_op("divzero", 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 32'h0000_0005, 16'h0000,
          1'b0, 1, 1'b1, 16'hDEAD, 16'hBEEF,
          '{wr_en:1'b0, wr_dx_en:1'b0, wr_ax:16'h0000, wr_dx:16'h0000, fault:1'b1, timeout:1'b0});

    // Divider never answers: FAULT must follow the 31st WAIT cycle.
    launch(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0004,
           '{wr_en:1'b0, wr_dx_en:1'b0, wr_ax:16'h0000, wr_dx:16'h0000, fault:1'b1, timeout:1'b1});
    bus.req = 1'b0;
    step();
    n_wait = 0;
    while (!bus.done && n_wait < 100) begin
      n_wait++;
      step();
    end
    chk("timeout_wait_cycles", n_wait, 31);
    chk_result("timeout");
    step();
    chk("timeout_ready_after", bus.ready, 1'b1);
    chk("timeout_pulse_once",  bus.timeout, 1'b0);

    // Reset in WAIT, then a stale completion arrives while idle.
    launch(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0003,
           '{wr_en:1'b0, wr_dx_en:1'b0, wr_ax:16'h0000, wr_dx:16'h0000, fault:1'b0, timeout:1'b0});
    void'(sb.pop_back());
    bus.req = 1'b0;
    step();
    step();
    chk("rstwait_in_wait", bus.ready, 1'b0);
    reset = 1'b1;
    step();
    chk("rstwait_ready",    bus.ready,        1'b1);
    chk("rstwait_done",     bus.done,         1'b0);
    chk("rstwait_fault",    bus.fault,        1'b0);
    chk("rstwait_wr_en",    bus.wr_en,        1'b0);
    chk("rstwait_dividend", bus.div_dividend, 32'h0);
    reset = 1'b0;
    bus.div_complete = 1'b1; bus.div_quotient = 16'h1234; bus.div_remainder = 16'h5678;
    step();
    chk("late_cmp_ready", bus.ready, 1'b1);
    chk("late_cmp_wr_en", bus.wr_en, 1'b0);
    chk("late_cmp_done",  bus.done,  1'b0);
    chk("late_cmp_start", bus.div_start, 1'b0);
    bus.div_complete = 1'b0;
    step();
    chk("late_cmp_wr_dx_en", bus.wr_dx_en, 1'b0);
    chk("late_cmp_done2",    bus.done,     1'b0);

    chk("start_count", n_starts, exp_starts);
    chk("sb_drained",  sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
